// File: rtl/loader_pkg.sv
// ============================================================================
// Module  : loader_pkg
// Purpose : Shared types and helpers for the serial program loader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int bytes_per_word(input int data_width);
        return (data_width + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_timeout.sv
// ============================================================================
// Module  : loader_timeout
// Purpose : Inter-byte idle counter; flags expiry on the TIMEOUT_CYCLES-th idle cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module  : program_loader
// Purpose : Frames UART bytes into instruction words and writes the text RAM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 8,
    parameter int         DATA_WIDTH     = 12,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  program_write,
    output logic [ADDR_WIDTH-1:0] program_addr,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    loader_state_t         r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [BCW-1:0]        r_byte_cnt;
    logic [8:0]            r_words_left;
    logic [7:0]            r_xor;
    logic                  r_program_write;
    logic [ADDR_WIDTH-1:0] r_program_addr;
    logic [DATA_WIDTH-1:0] r_program_cmd;
    logic                  r_cpu_hold;
    logic                  r_load_done;
    logic                  r_load_error;

    logic                  w_timeout_en;
    logic                  w_expired;
    logic                  w_last_byte;
    logic [DATA_WIDTH-1:0] w_acc_next;

    // Shifting left a byte at a time drops bits beyond DATA_WIDTH, so after
    // BPW bytes only the low DATA_WIDTH bits of the word remain.
    assign w_acc_next   = DATA_WIDTH'({r_acc, rx_data});
    assign w_last_byte  = (r_byte_cnt == BCW'(BPW - 1));
    assign w_timeout_en = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (rx_valid),
        .i_enable  (w_timeout_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_acc           <= '0;
            r_byte_cnt      <= '0;
            r_words_left    <= '0;
            r_xor           <= '0;
            r_program_write <= 1'b0;
            r_program_addr  <= '0;
            r_program_cmd   <= '0;
            r_cpu_hold      <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_error    <= 1'b0;
        end else begin
            r_program_write <= 1'b0;
            r_load_done     <= 1'b0;
            // Address advances the cycle after each write pulse.
            if (r_program_write) begin
                r_program_addr <= r_program_addr + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        r_state        <= LEN;
                        r_cpu_hold     <= 1'b1;
                        r_load_error   <= 1'b0;
                        r_program_addr <= '0;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        r_words_left <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        r_xor        <= rx_data;
                        r_byte_cnt   <= '0;
                        r_state      <= DATA;
                    end else if (w_expired) begin
                        r_state      <= IDLE;
                        r_load_error <= 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        r_acc <= w_acc_next;
                        r_xor <= r_xor ^ rx_data;
                        if (w_last_byte) begin
                            r_byte_cnt      <= '0;
                            r_program_write <= 1'b1;
                            r_program_cmd   <= w_acc_next;
                            r_words_left    <= r_words_left - 9'd1;
                            if (r_words_left == 9'd1) begin
                                r_state <= CSUM;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state      <= IDLE;
                        r_load_error <= 1'b1;
                    end
                end
                CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == r_xor) begin
                            r_state     <= DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= IDLE;
                            r_load_error <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state      <= IDLE;
                        r_load_error <= 1'b1;
                    end
                end
                DONE: begin
                    r_cpu_hold <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign program_write = r_program_write;
    assign program_addr  = r_program_addr;
    assign program_cmd   = r_program_cmd;
    assign cpu_hold      = r_cpu_hold;
    assign busy          = (r_state != IDLE);
    assign load_done     = r_load_done;
    assign load_error    = r_load_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module  : tb_program_loader
// Purpose : Self-checking bench for program_loader with a frame-level model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int         AW   = 8;
    localparam int         DW   = 12;
    localparam int         TO   = 100;
    localparam int         BPW  = (DW + 7) / 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          program_write;
    logic [AW-1:0] program_addr;
    logic [DW-1:0] program_cmd;
    logic          cpu_hold;
    logic          busy;
    logic          load_done;
    logic          load_error;

    program_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .program_write (program_write),
        .program_addr  (program_addr),
        .program_cmd   (program_cmd),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: position within the frame decides the meaning of each byte.
    int            m_phase = 0;   // 0 idle, 1 in frame, 2 done cycle
    int            m_pos   = 0;
    int            m_n     = 0;
    int            m_idle  = 0;
    int            m_acc   = 0;
    logic [7:0]    m_x     = 8'h00;
    logic          e_write = 1'b0;
    logic [DW-1:0] e_cmd   = '0;
    logic [AW-1:0] e_addr  = '0;
    logic          e_hold  = 1'b0;
    logic          e_err   = 1'b0;
    logic          e_done  = 1'b0;
    logic          e_busy  = 1'b0;

    logic [DW-1:0] dut_mem [256];
    int            wr_count   = 0;
    int            done_count = 0;
    logic [AW-1:0] last_wr_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_n = 0; m_idle = 0; m_acc = 0; m_x = 8'h00;
        e_write = 1'b0; e_cmd = '0; e_addr = '0; e_hold = 1'b0;
        e_err = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic nwrite;
        logic ndone;
        nwrite = 1'b0;
        ndone  = 1'b0;
        if (e_write) e_addr = e_addr + 8'd1;
        case (m_phase)
            0: begin
                if (v && d == SYNC) begin
                    m_phase = 1; m_pos = 0; m_idle = 0;
                    e_hold = 1'b1; e_err = 1'b0; e_addr = '0;
                end
            end
            1: begin
                if (v) begin
                    m_idle = 0;
                    if (m_pos == 0) begin
                        m_n = (d == 8'd0) ? 256 : int'(d);
                        m_x = d;
                    end else if (m_pos <= m_n * BPW) begin
                        m_x = m_x ^ d;
                        m_acc = ((m_pos - 1) % BPW == 0) ? int'(d) : ((m_acc << 8) | int'(d));
                        if (m_pos % BPW == 0) begin
                            nwrite = 1'b1;
                            e_cmd  = DW'(m_acc);
                        end
                    end else if (d == m_x) begin
                        m_phase = 2; ndone = 1'b1;
                    end else begin
                        m_phase = 0; e_err = 1'b1;
                    end
                    m_pos++;
                end else begin
                    m_idle++;
                    if (m_idle >= TO) begin
                        m_phase = 0; e_err = 1'b1;
                    end
                end
            end
            default: begin
                m_phase = 0; e_hold = 1'b0;
            end
        endcase
        e_write = nwrite;
        e_done  = ndone;
        e_busy  = (m_phase != 0);
    endtask

    // Every cycle: DUT outputs against the model, plus capture of RAM writes.
    always @(negedge clk) begin
        check("program_write", 32'(program_write), 32'(e_write));
        check("program_addr",  32'(program_addr),  32'(e_addr));
        check("cpu_hold",      32'(cpu_hold),      32'(e_hold));
        check("busy",          32'(busy),          32'(e_busy));
        check("load_done",     32'(load_done),     32'(e_done));
        check("load_error",    32'(load_error),    32'(e_err));
        if (e_write) check("program_cmd", 32'(program_cmd), 32'(e_cmd));
        if (program_write === 1'b1) begin
            dut_mem[program_addr] = program_cmd;
            last_wr_addr = program_addr;
            wr_count++;
        end
        if (load_done === 1'b1) done_count++;
    end

    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        if (!reset) model_step(v, d);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
        int g;
        foreach (q[i]) begin
            cycle(1'b1, q[i]);
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            idle(g);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] f1[$];
        logic [7:0] b;
        int         wr_before;
        int         done_before;
        int         n;
        int         k;

        idle(2);
        check("rst_write", 32'(program_write), 32'd0);
        check("rst_addr",  32'(program_addr),  32'd0);
        check("rst_hold",  32'(cpu_hold),      32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        reset = 1'b0;
        idle(2);

        // Two-word frame; checksum is derived rather than typed in.
        f1 = {SYNC, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56};
        f1.push_back(xsum(f1));
        check("csum_value", 32'(f1[6]), 32'h72);
        send_bytes(f1, 1);
        idle(3);
        check("t1_mem0", 32'(dut_mem[0]), 32'h123);
        check("t1_mem1", 32'(dut_mem[1]), 32'h456);
        check("t1_done_count", 32'(done_count), 32'd1);
        check("t1_error", 32'(load_error), 32'd0);
        check("t1_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum, then a good frame clears the error.
        wr_before = wr_count;
        q = {SYNC, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h00};
        send_bytes(q, 0);
        idle(3);
        check("t2_writes", 32'(wr_count - wr_before), 32'd2);
        check("t2_done_count", 32'(done_count), 32'd1);
        check("t2_error", 32'(load_error), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        send_bytes(f1, 0);
        idle(3);
        check("t2b_error", 32'(load_error), 32'd0);
        check("t2b_hold", 32'(cpu_hold), 32'd0);

        // Timeout after a partial word.
        wr_before = wr_count;
        q = {SYNC, 8'h01, 8'h0F};
        send_bytes(q, 0);
        idle(TO + 5);
        check("t3_writes", 32'(wr_count - wr_before), 32'd0);
        check("t3_error", 32'(load_error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd1);

        // N=0 means 256 words; upper nibble of each first byte is discarded.
        wr_before   = wr_count;
        done_before = done_count;
        q = {SYNC, 8'h00};
        for (int i = 0; i < 256; i++) begin
            q.push_back(8'(i) ^ 8'h3C);
            q.push_back(8'(i));
        end
        q.push_back(xsum(q));
        send_bytes(q, 0);
        idle(1);
        check("t4_addr_wrap", 32'(program_addr), 32'd0);
        idle(2);
        check("t4_writes", 32'(wr_count - wr_before), 32'd256);
        check("t4_last_addr", 32'(last_wr_addr), 32'hFF);
        check("t4_mem0", 32'(dut_mem[0]), 32'hC00);
        check("t4_mem16", 32'(dut_mem[16]), 32'hC10);
        check("t4_mem255", 32'(dut_mem[255]), 32'h3FF);
        check("t4_done", 32'(done_count - done_before), 32'd1);

        // Junk in IDLE ignored; sync value inside data is plain data.
        q = {8'h11, 8'h22, SYNC, 8'h01, 8'h0A, SYNC, 8'hAE};
        send_bytes(q, 0);
        idle(3);
        check("t5_mem0", 32'(dut_mem[0]), 32'hAA5);
        check("t5_error", 32'(load_error), 32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd0);

        // Asynchronous reset in the middle of DATA.
        q = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33};
        send_bytes(q, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("t6_write", 32'(program_write), 32'd0);
        check("t6_addr",  32'(program_addr),  32'd0);
        check("t6_cmd",   32'(program_cmd),   32'd0);
        check("t6_hold",  32'(cpu_hold),      32'd0);
        check("t6_busy",  32'(busy),          32'd0);
        check("t6_error", 32'(load_error),    32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // Randomized frames: junk, bad checksums, truncations, random gaps.
        for (int f = 0; f < 30; f++) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                cycle(1'b1, b);
            end
            n = $urandom_range(1, 5);
            q = {SYNC, 8'(n)};
            for (int j = 0; j < n * BPW; j++) q.push_back(8'($urandom_range(0, 255)));
            q.push_back(xsum(q) ^ (($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00));
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, q.size() - 1);
                while (q.size() > k) void'(q.pop_back());
                send_bytes(q, 2);
                idle(TO + 3);
            end else begin
                send_bytes(q, 2);
                idle($urandom_range(1, 3));
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
